// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader and the fetch stage.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    localparam int FRAME_BYTES_PER_WORD = 4;
    localparam int IMEM_DEPTH_DEFAULT   = 1024;

endpackage

// File: rtl/byte_assembler.sv
// Packs a stream of UART bytes into little-endian 32-bit words.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int                CNT_W     = $clog2(FRAME_BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FRAME_BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      shift_q;

    // Bytes enter at the top, so after four of them the first byte sits in [7:0].
    assign word       = {byte_data, shift_q[31:8]};
    assign word_valid = byte_valid && !clear && (byte_cnt == LAST_BYTE);

    // NOTE: reset is synchronous here, so rst lives inside the clocked block as a plain data condition.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            shift_q  <= word;
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program image over UART and writes it into
// instruction memory while holding the pipeline.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter  int IMEM_DEPTH     = IMEM_DEPTH_DEFAULT,
    parameter  int TIMEOUT_CYCLES = 1_000_000,
    localparam int ADDR_W         = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash,
    input  logic              byte_received,
    input  logic [7:0]        uart_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              hold_pipeline,
    output logic              load_done,
    output logic              load_error
);

    localparam int              IDX_W    = ADDR_W + 1;
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    loader_state_t    state;
    logic             flash_q;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] word_count;
    logic [IDX_W-1:0] last_idx;
    logic [TO_W-1:0]  timeout_cnt;
    logic             in_frame;
    logic             asm_valid;
    logic [31:0]      asm_word;

    assign in_frame = (state == LEN) || (state == DATA);
    assign last_idx = word_count - IDX_W'(1);

    // Outside a frame the assembler is held clear, so an aborted partial word never survives.
    byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (!in_frame),
        .byte_valid (byte_received),
        .byte_data  (uart_data),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            flash_q       <= 1'b0;
            word_idx      <= '0;
            word_count    <= '0;
            timeout_cnt   <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            hold_pipeline <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            flash_q   <= flash;
            imem_we   <= 1'b0;
            load_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (flash && !flash_q) begin
                        state         <= LEN;
                        load_error    <= 1'b0;
                        hold_pipeline <= 1'b1;
                        timeout_cnt   <= '0;
                    end
                end

                LEN, DATA: begin
                    // Abort beats a completed word; a strobe beats the timeout.
                    if (!flash) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (asm_valid) begin
                        timeout_cnt <= '0;
                        if (state == LEN) begin
                            if (asm_word == 32'd0 || asm_word > 32'(IMEM_DEPTH)) begin
                                state      <= ERROR;
                                load_error <= 1'b1;
                            end else begin
                                word_count <= asm_word[IDX_W-1:0];
                                word_idx   <= '0;
                                state      <= DATA;
                            end
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= asm_word;
                            word_idx   <= word_idx + IDX_W'(1);
                            if (word_idx == last_idx) begin
                                state <= DONE;
                            end
                        end
                    end else if (byte_received) begin
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TO_LIMIT) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end

                DONE: begin
                    load_done     <= 1'b1;
                    hold_pipeline <= 1'b0;
                    state         <= IDLE;
                end

                ERROR: begin
                    if (!flash) begin
                        state         <= IDLE;
                        hold_pipeline <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: table of whole-frame loads plus multi-cycle corner cases.
module tb_imem_uart_loader;

    localparam int DEPTH = 1024;
    localparam int TO    = 100;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          flash;
    logic          byte_received;
    logic [7:0]    uart_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          hold_pipeline;
    logic          load_done;
    logic          load_error;

    imem_uart_loader #(
        .IMEM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flash         (flash),
        .byte_received (byte_received),
        .uart_data     (uart_data),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .hold_pipeline (hold_pipeline),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (load_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic strobe_byte(input logic [7:0] b, input int gap);
        uart_data     = b;
        byte_received = 1'b1;
        tick(1);
        byte_received = 1'b0;
        tick(gap);
    endtask

    // First byte on the wire is bytes[7:0].
    task automatic send_bytes(input logic [127:0] bytes, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            strobe_byte(bytes[i*8 +: 8], gap);
        end
    endtask

    task automatic start_load();
        flash = 1'b1;
        tick(2);
    endtask

    task automatic end_load();
        flash = 1'b0;
        tick(4);
    endtask

    typedef struct {
        logic [127:0] bytes;
        int           nb;
        int           exp_writes;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic         exp_err;
        int           exp_done;
        logic         exp_hold;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{bytes: 128'h002000B3_00000013_00000002, nb: 12, exp_writes: 2,
                    w0: 32'h00000013, w1: 32'h002000B3, exp_err: 1'b0, exp_done: 1, exp_hold: 1'b0};
        vecs[1] = '{bytes: 128'h00000000, nb: 4, exp_writes: 0,
                    w0: 32'h0, w1: 32'h0, exp_err: 1'b1, exp_done: 0, exp_hold: 1'b1};
        vecs[2] = '{bytes: 128'h00000401, nb: 4, exp_writes: 0,
                    w0: 32'h0, w1: 32'h0, exp_err: 1'b1, exp_done: 0, exp_hold: 1'b1};
        vecs[3] = '{bytes: 128'hDEADBEEF_00000001, nb: 8, exp_writes: 1,
                    w0: 32'hDEADBEEF, w1: 32'h0, exp_err: 1'b0, exp_done: 1, exp_hold: 1'b0};

        rst           = 1'b1;
        flash         = 1'b0;
        byte_received = 1'b0;
        uart_data     = 8'h00;
        tick(3);
        check("reset_ctrl", {28'd0, imem_we, hold_pipeline, load_done, load_error}, 32'd0);
        check("reset_addr", 32'(imem_addr), 32'd0);
        check("reset_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        tick(2);
        check("idle_ctrl", {28'd0, imem_we, hold_pipeline, load_done, load_error}, 32'd0);

        // Bytes while idle must be ignored.
        clear_log();
        send_bytes(128'h00000013_00000001, 8, 1);
        tick(3);
        check("idle_bytes_writes", wr_addr.size(), 0);
        check("idle_bytes_hold", 32'(hold_pipeline), 32'd0);

        for (int i = 0; i < 4; i++) begin
            clear_log();
            start_load();
            check($sformatf("v%0d_hold_start", i), 32'(hold_pipeline), 32'd1);
            send_bytes(vecs[i].bytes, vecs[i].nb, 2);
            tick(6);
            check($sformatf("v%0d_writes", i), wr_addr.size(), vecs[i].exp_writes);
            for (int w = 0; w < vecs[i].exp_writes; w++) begin
                check($sformatf("v%0d_addr%0d", i, w), wr_addr[w], w);
                check($sformatf("v%0d_data%0d", i, w), wr_data[w], (w == 0) ? vecs[i].w0 : vecs[i].w1);
            end
            check($sformatf("v%0d_err", i), 32'(load_error), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_done_cnt", i), done_cnt, vecs[i].exp_done);
            check($sformatf("v%0d_hold", i), 32'(hold_pipeline), 32'(vecs[i].exp_hold));
            if (vecs[i].exp_done != 0) begin
                check($sformatf("v%0d_done_latency", i), done_cyc - wr_cyc[wr_cyc.size()-1], 1);
            end
            end_load();
            check($sformatf("v%0d_hold_end", i), 32'(hold_pipeline), 32'd0);
            check($sformatf("v%0d_err_end", i), 32'(load_error), 32'(vecs[i].exp_err));
        end

        // Timeout: length 1, two data bytes, then silence.
        clear_log();
        start_load();
        send_bytes(128'h3412_00000001, 6, 2);
        check("to_err_clear_on_start", 32'(load_error), 32'd0);
        tick(50);
        check("to_not_early", 32'(load_error), 32'd0);
        for (int k = 0; k < 300 && !load_error; k++) tick(1);
        check("to_err", 32'(load_error), 32'd1);
        check("to_hold", 32'(hold_pipeline), 32'd1);
        check("to_writes", wr_addr.size(), 0);
        end_load();
        check("to_hold_end", 32'(hold_pipeline), 32'd0);

        // Abort after one of three words.
        clear_log();
        start_load();
        send_bytes(128'h12345678_00000003, 8, 1);
        tick(4);
        flash = 1'b0;
        tick(4);
        check("abort_writes", wr_addr.size(), 1);
        check("abort_addr0", wr_addr[0], 0);
        check("abort_data0", wr_data[0], 32'h12345678);
        check("abort_err", 32'(load_error), 32'd1);
        check("abort_hold", 32'(hold_pipeline), 32'd0);
        check("abort_done", done_cnt, 0);

        // Back-to-back strobes every cycle, N=3.
        clear_log();
        start_load();
        send_bytes(128'hC0C1C2C3_B0B1B2B3_A0A1A2A3_00000003, 16, 0);
        tick(4);
        check("b2b_writes", wr_addr.size(), 3);
        check("b2b_addr0", wr_addr[0], 0);
        check("b2b_addr1", wr_addr[1], 1);
        check("b2b_addr2", wr_addr[2], 2);
        check("b2b_data0", wr_data[0], 32'hA0A1A2A3);
        check("b2b_data1", wr_data[1], 32'hB0B1B2B3);
        check("b2b_data2", wr_data[2], 32'hC0C1C2C3);
        check("b2b_spacing", wr_cyc[2] - wr_cyc[1], 4);
        check("b2b_done", done_cnt, 1);
        check("b2b_err", 32'(load_error), 32'd0);
        end_load();

        // Length equal to the memory depth is accepted.
        clear_log();
        start_load();
        send_bytes(128'h00000400, 4, 1);
        tick(4);
        check("depth_err", 32'(load_error), 32'd0);
        check("depth_hold", 32'(hold_pipeline), 32'd1);
        end_load();
        check("depth_abort_err", 32'(load_error), 32'd1);
        check("depth_writes", wr_addr.size(), 0);

        // Reset in the middle of DATA, then a clean reload.
        clear_log();
        start_load();
        send_bytes(128'hBBAA_DEADBEEF_00000002, 10, 1);
        rst   = 1'b1;
        flash = 1'b0;
        tick(1);
        check("rst_mid_ctrl", {28'd0, imem_we, hold_pipeline, load_done, load_error}, 32'd0);
        check("rst_mid_addr", 32'(imem_addr), 32'd0);
        check("rst_mid_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        tick(2);
        clear_log();
        start_load();
        send_bytes(128'h0BADF00D_00000001, 8, 1);
        tick(6);
        check("reload_writes", wr_addr.size(), 1);
        check("reload_addr0", wr_addr[0], 0);
        check("reload_data0", wr_data[0], 32'h0BADF00D);
        check("reload_done", done_cnt, 1);
        check("reload_err", 32'(load_error), 32'd0);
        end_load();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
